// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the RV32M multiply group: the mulctl encoding that the
// controller decodes func3 into, and the multiplier FSM state type.
package seq_multiplier_pkg;

  localparam logic [1:0] MUL_LO  = 2'b00;
  localparam logic [1:0] MUL_HSS = 2'b01;
  localparam logic [1:0] MUL_HSU = 2'b10;
  localparam logic [1:0] MUL_HUU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes and applies the sign correction once at the end.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  mul_state_t        state, state_next;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   result_q;
  logic [CW-1:0]     cnt_q;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc_sum;
  logic [2*XLEN-1:0] product;
  logic              last_iter;

  // The most-negative operand negates to itself, which is exactly its magnitude.
  assign a_neg = ((mulctl == MUL_HSS) || (mulctl == MUL_HSU)) && a[XLEN-1];
  assign b_neg = (mulctl == MUL_HSS) && b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product   = neg_q ? -acc_sum : acc_sum;
  assign last_iter = (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MUL_LO;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= mulctl;
            neg_q    <= a_neg ^ b_neg;
            mcand_q  <= {{XLEN{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          // The final iteration's partial sum feeds the result directly.
          if (last_iter) begin
            if (op_q == MUL_LO) result_q <= product[XLEN-1:0];
            else                result_q <= product[2*XLEN-1:XLEN];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == ST_RUN) || (state == ST_DONE);
  assign done   = (state == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed RV32M corners, start spam,
// async reset abort and randomized ops against a wide-arithmetic model.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int XLEN = 32;
  localparam int N_RAND = 150;

  typedef struct {
    logic [XLEN-1:0] exp;
    int              acc_cyc;
    string           name;
  } sb_entry_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mulctl = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int        tests = 0;
  int        fails = 0;
  int        cyc = 0;
  int        accept_cnt = 0;
  int        done_cnt = 0;
  logic      prev_done = 1'b0;
  sb_entry_t sb[$];

  seq_multiplier #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mulctl(mulctl),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: exact signed product of sign/zero-extended operands.
  function automatic logic [XLEN-1:0] ref_mul(logic [1:0] op, logic [XLEN-1:0] x, logic [XLEN-1:0] y);
    logic signed [2*XLEN+1:0] sx, sy, p;
    sx = (op == MUL_HSS || op == MUL_HSU) ? {{(XLEN+2){x[XLEN-1]}}, x} : {{(XLEN+2){1'b0}}, x};
    sy = (op == MUL_HSS) ? {{(XLEN+2){y[XLEN-1]}}, y} : {{(XLEN+2){1'b0}}, y};
    p = sx * sy;
    return (op == MUL_LO) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    logic [XLEN-1:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return $urandom;
  endfunction

  task automatic check_output(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // Waits for IDLE, issues one op and records its expected result.
  task automatic apply_stimulus(logic [1:0] op, logic [XLEN-1:0] x, logic [XLEN-1:0] y,
                                logic [XLEN-1:0] exp, string name);
    sb_entry_t e;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check_output({name, "_idle_timeout"}, 32'(busy), 32'h0);
    start = 1'b1; mulctl = op; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output({name, "_busy_rise"}, 32'(busy), 32'h1);
    e.exp = exp; e.acc_cyc = cyc; e.name = name;
    sb.push_back(e);
    accept_cnt++;
  endtask

  task automatic drain(string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) check_output({name, "_drain_timeout"}, 32'(sb.size()), 32'h0);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every done and checks value and latency.
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n) begin
      if (prev_done) check_output("busy_after_done", 32'(busy), 32'h0);
      if (done) begin
        done_cnt++;
        check_output("busy_in_done", 32'(busy), 32'h1);
        if (sb.size() == 0) begin
          check_output("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check_output(e.name, result, e.exp);
          check_output({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(XLEN));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    sb_entry_t e;
    logic [1:0]      op;
    logic [XLEN-1:0] x, y;

    #12;
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    check_output("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(MUL_LO,  32'd7,         32'd6,         32'h0000_002A, "mul_7x6");
    apply_stimulus(MUL_HSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    apply_stimulus(MUL_HSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
    apply_stimulus(MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    apply_stimulus(MUL_HSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    apply_stimulus(MUL_LO,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1");
    drain("directed");
    check_output("result_held", result, 32'h0000_0001);

    // Start held high through the whole op with changing operands.
    apply_stimulus(MUL_LO, 32'd7, 32'd6, 32'h0000_002A, "spam_first");
    repeat (XLEN + 1) begin
      @(negedge clk);
      start = 1'b1; mulctl = 2'($urandom); a = $urandom; b = $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    op = 2'($urandom); x = pick_operand(); y = pick_operand();
    mulctl = op; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("spam_second_busy", 32'(busy), 32'h1);
    e.exp = ref_mul(op, x, y); e.acc_cyc = cyc; e.name = "spam_second";
    sb.push_back(e);
    accept_cnt++;
    drain("spam");

    for (int i = 0; i < 4 * N_RAND; i++) begin
      op = 2'(i % 4);
      x = pick_operand();
      y = pick_operand();
      apply_stimulus(op, x, y, ref_mul(op, x, y), "random_op");
    end
    drain("random");

    // Asynchronous reset in the middle of RUN aborts without a done pulse.
    apply_stimulus(MUL_HUU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, "aborted");
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'h0);
    check_output("abort_done", 32'(done), 32'h0);
    check_output("abort_result", result, 32'h0);
    accept_cnt -= sb.size();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(MUL_LO, 32'd3, 32'd5, 32'h0000_000F, "mul_3x5_after_reset");
    drain("final");
    check_output("done_count", 32'(done_cnt), 32'(accept_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
